// File: rtl/mmio_router_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_router_pkg
// Brief   : Shared types, constants and region decode helper for the router.
// Revision: 1.0
// ============================================================================
package mmio_router_pkg;

    localparam int c_MAX_REGIONS = 16;
    localparam int c_REGION_W    = 4;

    localparam logic [31:0] c_ERROR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Returns {hit, region}; the lowest-numbered hitting region wins.
    function automatic logic [c_REGION_W:0] decode_hits(input logic [c_MAX_REGIONS-1:0] hits);
        logic [c_REGION_W:0] result;
        result = '0;
        for (int i = c_MAX_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) result = {1'b1, c_REGION_W'(i)};
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_router_channel.sv
`default_nettype none
// ============================================================================
// Module  : mmio_router_channel
// Brief   : One request channel: latches a decoded request, issues it to the
//           selected device port, and returns ack/data/error with timeout.
// Revision: 1.0
// ============================================================================
module mmio_router_channel
    import mmio_router_pkg::*;
#(
    parameter int                  NUM_REGIONS    = 4,
    parameter int                  INDEX_WIDTH    = 32,
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA   = DATA_WIDTH'(c_ERROR_DATA)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_req,
    input  logic [INDEX_WIDTH-1:0]           i_index,
    input  logic [INDEX_WIDTH-1:0]           i_rel_index,
    input  logic                             i_hit,
    input  logic [c_REGION_W-1:0]            i_region,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    output logic [NUM_REGIONS-1:0]           o_dev_req,
    output logic [NUM_REGIONS*INDEX_WIDTH-1:0] o_dev_index,
    output logic [NUM_REGIONS*DATA_WIDTH-1:0]  o_dev_data,
    input  logic [NUM_REGIONS-1:0]           i_dev_ack,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0]  i_dev_rdata,
    output logic                             o_ack,
    output logic                             o_error,
    output logic [DATA_WIDTH-1:0]            o_rdata,
    output logic [INDEX_WIDTH-1:0]           o_err_index
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e                   r_state;
    logic [c_REGION_W-1:0]    r_region;
    logic [INDEX_WIDTH-1:0]   r_index;
    logic [INDEX_WIDTH-1:0]   r_rel_index;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_CNT_W-1:0]       r_count;
    logic                     r_ack;
    logic                     r_error;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic [NUM_REGIONS-1:0]   w_sel;
    logic                     w_sel_ack;
    logic [DATA_WIDTH-1:0]    w_sel_data;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_dev
        assign w_sel[g]                                 = (r_state == ST_ISSUE) && (r_region == c_REGION_W'(g));
        assign o_dev_req[g]                             = w_sel[g];
        assign o_dev_index[g*INDEX_WIDTH +: INDEX_WIDTH] = w_sel[g] ? r_rel_index : '0;
        assign o_dev_data[g*DATA_WIDTH +: DATA_WIDTH]    = w_sel[g] ? r_wdata : '0;
    end

    // Only the selected region's ack/data is observed; others are masked.
    assign w_sel_ack = |(i_dev_ack & w_sel);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_sel[i]) w_sel_data = i_dev_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_region    <= '0;
            r_index     <= '0;
            r_rel_index <= '0;
            r_wdata     <= '0;
            r_count     <= '0;
            r_ack       <= 1'b0;
            r_error     <= 1'b0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_region    <= i_region;
                        r_index     <= i_index;
                        r_rel_index <= i_rel_index;
                        r_wdata     <= i_wdata;
                        r_count     <= '0;
                        if (i_hit) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            r_state <= ST_RESPOND;
                            r_ack   <= 1'b1;
                            r_error <= 1'b1;
                            r_rdata <= ERROR_DATA;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_sel_ack) begin
                        r_state <= ST_RESPOND;
                        r_ack   <= 1'b1;
                        r_error <= 1'b0;
                        r_rdata <= w_sel_data;
                    end else if ((TIMEOUT_CYCLES != 0) && (r_count == c_CNT_LAST)) begin
                        r_state <= ST_RESPOND;
                        r_ack   <= 1'b1;
                        r_error <= 1'b1;
                        r_rdata <= ERROR_DATA;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    r_state <= ST_RELEASE;
                    r_ack   <= 1'b0;
                    r_error <= 1'b0;
                    r_rdata <= '0;
                end
                ST_RELEASE: begin
                    if (!i_req) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_error     = r_error;
    assign o_rdata     = r_rdata;
    assign o_err_index = r_index;

endmodule
`default_nettype wire

// File: rtl/mmio_region_router.sv
`default_nettype none
// ============================================================================
// Module  : mmio_region_router
// Brief   : Routes one MMIO host port to NUM_REGIONS base/bound device ports
//           with decode-error and timeout responses. Optional error log under
//           MMIO_ROUTER_ERROR_LOG_EN.
// Revision: 1.0
// ============================================================================
module mmio_region_router
    import mmio_router_pkg::*;
#(
    parameter int NUM_REGIONS    = 4,
    parameter int INDEX_WIDTH    = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_REGIONS-1:0][INDEX_WIDTH-1:0] REGION_BASE =
        {32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000},
    parameter logic [NUM_REGIONS-1:0][INDEX_WIDTH-1:0] REGION_BOUND =
        {32'h50000000, 32'h40000000, 32'h30000000, 32'h20000000},
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(c_ERROR_DATA)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               host_read_req,
    input  logic [INDEX_WIDTH-1:0]             host_read_index,
    output logic                               host_read_ack,
    output logic [DATA_WIDTH-1:0]              host_read_data,
    output logic                               host_read_error,
    input  logic                               host_write_req,
    input  logic [INDEX_WIDTH-1:0]             host_write_index,
    input  logic [DATA_WIDTH-1:0]              host_write_data,
    output logic                               host_write_ack,
    output logic                               host_write_error,
    output logic [NUM_REGIONS-1:0]             dev_read_req,
    output logic [NUM_REGIONS*INDEX_WIDTH-1:0] dev_read_index,
    input  logic [NUM_REGIONS-1:0]             dev_read_ack,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0]  dev_read_data,
    output logic [NUM_REGIONS-1:0]             dev_write_req,
    output logic [NUM_REGIONS*INDEX_WIDTH-1:0] dev_write_index,
    output logic [NUM_REGIONS*DATA_WIDTH-1:0]  dev_write_data,
    input  logic [NUM_REGIONS-1:0]             dev_write_ack
`ifdef MMIO_ROUTER_ERROR_LOG_EN
    ,
    output logic [15:0]                        error_count,
    output logic [INDEX_WIDTH-1:0]             last_error_index
`endif
);

    logic [c_MAX_REGIONS-1:0] w_rd_hits, w_wr_hits;
    logic [c_REGION_W:0]      w_rd_dec, w_wr_dec;
    logic [INDEX_WIDTH-1:0]   w_rd_base, w_wr_base;
    logic [INDEX_WIDTH-1:0]   w_rd_err_index, w_wr_err_index;
    logic [DATA_WIDTH-1:0]    w_unused_wr_rdata;
    logic [NUM_REGIONS*DATA_WIDTH-1:0] w_unused_rd_dev_data;

    always_comb begin
        w_rd_hits = '0;
        w_wr_hits = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_rd_hits[i] = (host_read_index  >= REGION_BASE[i]) && (host_read_index  < REGION_BOUND[i]);
            w_wr_hits[i] = (host_write_index >= REGION_BASE[i]) && (host_write_index < REGION_BOUND[i]);
        end
    end

    assign w_rd_dec = decode_hits(w_rd_hits);
    assign w_wr_dec = decode_hits(w_wr_hits);

    always_comb begin
        w_rd_base = '0;
        w_wr_base = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_rd_dec[c_REGION_W-1:0] == c_REGION_W'(i)) w_rd_base = REGION_BASE[i];
            if (w_wr_dec[c_REGION_W-1:0] == c_REGION_W'(i)) w_wr_base = REGION_BASE[i];
        end
    end

    mmio_router_channel #(
        .NUM_REGIONS   (NUM_REGIONS),
        .INDEX_WIDTH   (INDEX_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERROR_DATA    (ERROR_DATA)
    ) u_read (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_req      (host_read_req),
        .i_index    (host_read_index),
        .i_rel_index(host_read_index - w_rd_base),
        .i_hit      (w_rd_dec[c_REGION_W]),
        .i_region   (w_rd_dec[c_REGION_W-1:0]),
        .i_wdata    ('0),
        .o_dev_req  (dev_read_req),
        .o_dev_index(dev_read_index),
        .o_dev_data (w_unused_rd_dev_data),
        .i_dev_ack  (dev_read_ack),
        .i_dev_rdata(dev_read_data),
        .o_ack      (host_read_ack),
        .o_error    (host_read_error),
        .o_rdata    (host_read_data),
        .o_err_index(w_rd_err_index)
    );

    mmio_router_channel #(
        .NUM_REGIONS   (NUM_REGIONS),
        .INDEX_WIDTH   (INDEX_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERROR_DATA    (ERROR_DATA)
    ) u_write (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_req      (host_write_req),
        .i_index    (host_write_index),
        .i_rel_index(host_write_index - w_wr_base),
        .i_hit      (w_wr_dec[c_REGION_W]),
        .i_region   (w_wr_dec[c_REGION_W-1:0]),
        .i_wdata    (host_write_data),
        .o_dev_req  (dev_write_req),
        .o_dev_index(dev_write_index),
        .o_dev_data (dev_write_data),
        .i_dev_ack  (dev_write_ack),
        .i_dev_rdata('0),
        .o_ack      (host_write_ack),
        .o_error    (host_write_error),
        .o_rdata    (w_unused_wr_rdata),
        .o_err_index(w_wr_err_index)
    );

`ifdef MMIO_ROUTER_ERROR_LOG_EN
    logic [15:0]            r_error_count;
    logic [INDEX_WIDTH-1:0] r_last_error_index;
    logic                   w_rd_err_evt, w_wr_err_evt;
    logic [16:0]            w_count_sum;

    assign w_rd_err_evt = host_read_ack  & host_read_error;
    assign w_wr_err_evt = host_write_ack & host_write_error;
    assign w_count_sum  = {1'b0, r_error_count} + 17'(w_rd_err_evt) + 17'(w_wr_err_evt);

    // Read index takes priority when both channels report an error together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_error_count      <= '0;
            r_last_error_index <= '0;
        end else begin
            r_error_count <= w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
            if (w_rd_err_evt)      r_last_error_index <= w_rd_err_index;
            else if (w_wr_err_evt) r_last_error_index <= w_wr_err_index;
        end
    end

    assign error_count      = r_error_count;
    assign last_error_index = r_last_error_index;
`else
    logic [2*INDEX_WIDTH-1:0] w_unused_err_index;
    assign w_unused_err_index = {w_rd_err_index, w_wr_err_index};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmio_region_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_region_router
// Brief   : Directed scoreboard bench for mmio_region_router.
// Revision: 1.0
// ============================================================================
module tb_mmio_region_router;

    localparam int NR = 4;
    localparam int IW = 32;
    localparam int DW = 32;
    localparam logic [NR-1:0][IW-1:0] BASE  = {32'h10000000, 32'h30000000, 32'h20000000, 32'h10000000};
    localparam logic [NR-1:0][IW-1:0] BOUND = {32'h10000020, 32'h30000100, 32'h20000100, 32'h10000010};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic host_read_req = 1'b0, host_write_req = 1'b0;
    logic [IW-1:0] host_read_index = '0, host_write_index = '0;
    logic [DW-1:0] host_write_data = '0;
    logic host_read_ack, host_read_error, host_write_ack, host_write_error;
    logic [DW-1:0] host_read_data;
    logic [NR-1:0] dev_read_req, dev_write_req;
    logic [NR-1:0] dev_read_ack = '0, dev_write_ack = '0;
    logic [NR*IW-1:0] dev_read_index, dev_write_index;
    logic [NR*DW-1:0] dev_read_data = '0, dev_write_data;
`ifdef MMIO_ROUTER_ERROR_LOG_EN
    logic [15:0] error_count;
    logic [IW-1:0] last_error_index;
`endif

    mmio_region_router #(
        .NUM_REGIONS(NR), .INDEX_WIDTH(IW), .DATA_WIDTH(DW),
        .REGION_BASE(BASE), .REGION_BOUND(BOUND), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clk), .reset_n(reset_n),
        .host_read_req(host_read_req), .host_read_index(host_read_index),
        .host_read_ack(host_read_ack), .host_read_data(host_read_data),
        .host_read_error(host_read_error),
        .host_write_req(host_write_req), .host_write_index(host_write_index),
        .host_write_data(host_write_data), .host_write_ack(host_write_ack),
        .host_write_error(host_write_error),
        .dev_read_req(dev_read_req), .dev_read_index(dev_read_index),
        .dev_read_ack(dev_read_ack), .dev_read_data(dev_read_data),
        .dev_write_req(dev_write_req), .dev_write_index(dev_write_index),
        .dev_write_data(dev_write_data), .dev_write_ack(dev_write_ack)
`ifdef MMIO_ROUTER_ERROR_LOG_EN
        , .error_count(error_count), .last_error_index(last_error_index)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          region;
        logic [31:0] rel;
        logic [31:0] wdata;
        int          t0;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int exp_err_cnt = 0;
    logic [31:0] exp_last_idx = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device models: per-region latency, never-ack and return data.
    int          rd_lat[NR], wr_lat[NR], rd_cnt[NR], wr_cnt[NR];
    bit          rd_never[NR], wr_never[NR];
    logic [31:0] rd_val[NR];
    bit          noise = 0;
    int          rd_seen_region = -1, wr_seen_region = -1;
    logic [31:0] rd_seen_index = '0, wr_seen_index = '0, wr_seen_data = '0;
    int          rd_viol = 0, wr_viol = 0;

    initial begin
        for (int r = 0; r < NR; r++) begin
            rd_lat[r] = 0; wr_lat[r] = 0; rd_cnt[r] = 0; wr_cnt[r] = 0;
            rd_never[r] = 0; wr_never[r] = 0; rd_val[r] = '0;
        end
    end

    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            dev_read_ack[r] = 1'b0;
            if (dev_read_req[r]) begin
                if (rd_cnt[r] == 0) begin
                    rd_seen_region = r;
                    rd_seen_index  = dev_read_index[r*IW +: IW];
                end
                if (!rd_never[r] && rd_cnt[r] == rd_lat[r]) begin
                    dev_read_ack[r] = 1'b1;
                    dev_read_data[r*DW +: DW] = rd_val[r];
                end
                rd_cnt[r]++;
            end else begin
                rd_cnt[r] = 0;
                if (noise) dev_read_ack[r] = 1'b1;
            end
            dev_write_ack[r] = 1'b0;
            if (dev_write_req[r]) begin
                if (wr_cnt[r] == 0) begin
                    wr_seen_region = r;
                    wr_seen_index  = dev_write_index[r*IW +: IW];
                    wr_seen_data   = dev_write_data[r*DW +: DW];
                end
                if (!wr_never[r] && wr_cnt[r] == wr_lat[r]) dev_write_ack[r] = 1'b1;
                wr_cnt[r]++;
            end else begin
                wr_cnt[r] = 0;
            end
            if (!dev_read_req[r] && dev_read_index[r*IW +: IW] != '0) rd_viol++;
            if (!dev_write_req[r] && (dev_write_index[r*IW +: IW] != '0 || dev_write_data[r*DW +: DW] != '0)) wr_viol++;
        end
        if ($countones(dev_read_req) > 1)  rd_viol++;
        if ($countones(dev_write_req) > 1) wr_viol++;
    end

    // Monitors: pop and compare on every host ack.
    always @(negedge clk) begin
        if (reset_n && host_read_ack) begin
            if (rd_q.size() == 0) begin
                chk("rd_extra_ack", 64'(host_read_ack), 64'd0);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                chk("rd_data",    64'(host_read_data), 64'(e.data));
                chk("rd_error",   64'(host_read_error), 64'(e.err));
                chk("rd_latency", 64'(cyc + 1 - e.t0), 64'(e.lat));
                chk("rd_region",  64'(rd_seen_region), 64'(e.region));
                chk("rd_dev_idx", 64'(rd_seen_index), 64'(e.rel));
                chk("rd_req_low", 64'(dev_read_req), 64'd0);
                chk("rd_xregion", 64'(rd_viol), 64'd0);
                if (e.err) begin exp_err_cnt++; exp_last_idx = e.idx; end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && host_write_ack) begin
            if (wr_q.size() == 0) begin
                chk("wr_extra_ack", 64'(host_write_ack), 64'd0);
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                chk("wr_error",   64'(host_write_error), 64'(e.err));
                chk("wr_latency", 64'(cyc + 1 - e.t0), 64'(e.lat));
                chk("wr_region",  64'(wr_seen_region), 64'(e.region));
                chk("wr_dev_idx", 64'(wr_seen_index), 64'(e.rel));
                chk("wr_dev_data",64'(wr_seen_data), 64'(e.wdata));
                chk("wr_req_low", 64'(dev_write_req), 64'd0);
                chk("wr_xregion", 64'(wr_viol), 64'd0);
                if (e.err) begin exp_err_cnt++; exp_last_idx = e.idx; end
            end
        end
    end

    task automatic do_read(input logic [31:0] idx, input logic [31:0] data, input logic err,
                           input int lat, input int region, input logic [31:0] rel,
                           input int hold, input bit scramble);
        exp_t e;
        bit got;
        @(posedge clk); #1;
        e.idx = idx; e.data = data; e.err = err; e.lat = lat; e.region = region;
        e.rel = rel; e.wdata = '0; e.t0 = cyc + 1;
        rd_q.push_back(e);
        rd_seen_region = -1; rd_seen_index = '0;
        host_read_index = idx;
        host_read_req = 1'b1;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (host_read_ack) got = 1;
            else if (scramble && i > 0) host_read_index = $urandom;
        end
        if (!got) chk("rd_ack_timeout", 64'(got), 64'd1);
        repeat (hold) @(negedge clk);
        host_read_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_write(input logic [31:0] idx, input logic [31:0] wdata, input logic err,
                            input int lat, input int region, input logic [31:0] rel, input int hold);
        exp_t e;
        bit got;
        @(posedge clk); #1;
        e.idx = idx; e.data = '0; e.err = err; e.lat = lat; e.region = region;
        e.rel = rel; e.wdata = (region >= 0) ? wdata : '0; e.t0 = cyc + 1;
        wr_q.push_back(e);
        wr_seen_region = -1; wr_seen_index = '0; wr_seen_data = '0;
        host_write_index = idx;
        host_write_data = wdata;
        host_write_req = 1'b1;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (host_write_ack) got = 1;
            else if (i > 0) host_write_data = $urandom;
        end
        if (!got) chk("wr_ack_timeout", 64'(got), 64'd1);
        repeat (hold) @(negedge clk);
        host_write_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    logic any_out;
    always_comb begin
        any_out = |{host_read_ack, host_read_data, host_read_error, host_write_ack,
                    host_write_error, dev_read_req, dev_read_index, dev_write_req,
                    dev_write_index, dev_write_data};
`ifdef MMIO_ROUTER_ERROR_LOG_EN
        any_out = any_out | (|{error_count, last_error_index});
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(any_out), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", 64'(any_out), 64'd0);

        rd_lat[0] = 3; rd_val[0] = 32'h00001234;
        do_read(32'h10000005, 32'h00001234, 1'b0, 5, 0, 32'h5, 0, 1);
        do_write(32'h00000000, 32'h77777777, 1'b1, 1, -1, 32'h0, 0);

        // Device 0 never acks while every idle region drives a stray ack.
        rd_never[0] = 1; noise = 1;
        do_read(32'h10000007, 32'hDEADBEEF, 1'b1, 9, 0, 32'h7, 0, 0);
        rd_never[0] = 0; noise = 0;

        rd_lat[1] = 1; rd_val[1] = 32'hAAAA5555; wr_lat[2] = 4;
        fork
            do_read(32'h20000042, 32'hAAAA5555, 1'b0, 3, 1, 32'h42, 0, 1);
            do_write(32'h300000FF, 32'hCAFEF00D, 1'b0, 6, 2, 32'hFF, 0);
        join

        rd_lat[2] = 0; rd_val[2] = 32'h0BADF00D;
        do_read(32'h30000001, 32'h0BADF00D, 1'b0, 2, 2, 32'h1, 20, 0);

        rd_lat[3] = 0; rd_val[3] = 32'h33333333; wr_lat[3] = 2; wr_lat[0] = 0;
        do_read(32'h1000000F, 32'h00001234, 1'b0, 5, 0, 32'hF, 0, 0);
        do_read(32'h10000010, 32'h33333333, 1'b0, 2, 3, 32'h10, 0, 0);
        do_write(32'h10000020, 32'h12121212, 1'b1, 1, -1, 32'h0, 0);
        do_write(32'h1000001F, 32'h5A5A5A5A, 1'b0, 4, 3, 32'h1F, 0);
        do_read(32'h20000100, 32'hDEADBEEF, 1'b1, 1, -1, 32'h0, 0, 0);
        do_write(32'h10000000, 32'h0F0F0F0F, 1'b0, 2, 0, 32'h0, 0);

        wr_lat[1] = 2;
        fork
            do_read(32'h200000FF, 32'hAAAA5555, 1'b0, 3, 1, 32'hFF, 0, 0);
            do_write(32'h20000000, 32'h11112222, 1'b0, 4, 1, 32'h0, 0);
        join

        // Asynchronous reset while a read sits in ISSUE.
        rd_never[1] = 1;
        @(posedge clk); #1;
        host_read_index = 32'h20000010;
        host_read_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_dev_req", 64'(dev_read_req), 64'h2);
        #2 reset_n = 1'b0;
        #1 chk("mid_reset_outputs", 64'(any_out), 64'd0);
        exp_err_cnt = 0; exp_last_idx = '0;
        @(negedge clk);
        host_read_req = 1'b0;
        reset_n = 1'b1;
        rd_never[1] = 0;
        do_read(32'h20000010, 32'hAAAA5555, 1'b0, 3, 1, 32'h10, 0, 0);

        wr_never[3] = 1;
        do_write(32'h10000019, 32'h99999999, 1'b1, 9, 3, 32'h19, 0);
        wr_never[3] = 0;

        repeat (4) @(negedge clk);
        chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
`ifdef MMIO_ROUTER_ERROR_LOG_EN
        chk("error_count", 64'(error_count), 64'(exp_err_cnt));
        chk("last_error_index", 64'(last_error_index), 64'(exp_last_idx));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
